// File: rtl/spi_slave_if_pkg.sv
// spi_slave_if_pkg: shared FSM states, command codes and command decode helper
package spi_slave_if_pkg;
  typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA} state_t;
  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;
  function automatic state_t cmd_state(input logic b, input logic addr_rcvd);
    return !b ? WRITE : (addr_rcvd ? READ_DATA : READ_ADD);
  endfunction
endpackage

// File: rtl/spi_slave_if_piso.sv
// spi_slave_if_piso: W-bit load/shift-out register driving a registered serial output
module spi_slave_if_piso #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic         q,
  output logic         done
);
  localparam int CW = $clog2(W + 1);
  logic [W-1:0]  sh;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sh  <= '0;
      cnt <= '0;
      q   <= 1'b0;
    end else if (clr) begin
      sh  <= '0;
      cnt <= '0;
      q   <= 1'b0;
    end else if (load) begin
      sh  <= d;
      cnt <= CW'(W);
      q   <= 1'b0;
    end else if (cnt != '0) begin
      q   <= sh[W-1];
      sh  <= sh << 1;
      cnt <= cnt - CW'(1);
    end else
      q <= 1'b0;
  assign done = cnt == '0;
endmodule

// File: rtl/spi_slave_if.sv
// spi_slave_if: SPI slave front-end turning MOSI frames into RAM commands and RAM read data into MISO
module spi_slave_if
  import spi_slave_if_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SS_n,
  input  logic              MOSI,
  output logic              MISO,
  output logic [DATA_W+1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid
);
  localparam int FW = DATA_W + 2;
  localparam int CW = $clog2(FW);
  state_t        state;
  logic [FW-1:0] sh;
  logic [CW-1:0] cnt;
  logic          got, pend, armed, addr_rcvd, tx_done, load, last;
  assign last = cnt == CW'(DATA_W);
  assign load = state == READ_DATA && armed && tx_valid && !SS_n && tx_done;
  // got marks a finished frame so trailing bits under a held SS_n are dropped
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      sh        <= '0;
      cnt       <= '0;
      got       <= 1'b0;
      pend      <= 1'b0;
      armed     <= 1'b0;
      addr_rcvd <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
    end else begin
      rx_valid <= pend;
      pend     <= 1'b0;
      if (pend) rx_data <= sh;
      if (pend && state == READ_DATA && !SS_n) armed <= 1'b1;
      else if (load || SS_n) armed <= 1'b0;
      if (state == IDLE) begin
        cnt <= '0;
        got <= 1'b0;
        if (!SS_n) state <= CHK_CMD;
      end else if (state == CHK_CMD) begin
        sh    <= {sh[FW-2:0], MOSI};
        state <= SS_n ? IDLE : cmd_state(MOSI, addr_rcvd);
      end else begin
        if (!got) begin
          sh  <= {sh[FW-2:0], MOSI};
          cnt <= cnt + CW'(1);
          if (last) begin
            got  <= 1'b1;
            pend <= 1'b1;
            if (state == READ_ADD) addr_rcvd <= 1'b1;
            else if (state == READ_DATA) addr_rcvd <= 1'b0;
          end
        end
        if (SS_n) state <= IDLE;
      end
    end
  spi_slave_if_piso #(.W(DATA_W)) u_piso (
    .clk  (clk),
    .rst_n(rst_n),
    .load (load),
    .clr  (SS_n),
    .d    (tx_data),
    .q    (MISO),
    .done (tx_done)
  );
endmodule

// File: tb/tb_spi_slave_if.sv
// tb_spi_slave_if: directed and randomized SPI frames checked against a frame-level reference model
module tb_spi_slave_if;
  import spi_slave_if_pkg::*;
  logic       clk = 1'b0, rst_n = 1'b1, SS_n = 1'b1, MOSI = 1'b0, tx_valid = 1'b0;
  logic       MISO, rx_valid;
  logic [9:0] rx_data;
  logic [7:0] tx_data = '0;
  int         n_chk = 0, n_pass = 0;
  bit         addr = 1'b0;
  always #5 clk = ~clk;
  spi_slave_if #(.DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_valid(tx_valid)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask
  task automatic step(input logic ss, input logic mosi, input logic tv, input logic [7:0] td);
    @(negedge clk);
    SS_n = ss;
    MOSI = mosi;
    tx_valid = tv;
    tx_data = td;
    @(posedge clk);
    #1;
  endtask
  // edge 0 samples SS_n low, edges 1..10 carry frame bits MSB first;
  // len_low is the number of edges from edge 0 that see SS_n low
  task automatic frame(input logic [9:0] f, input int len_low, input int d,
                       input logic [7:0] td, input int rst_at);
    bit complete, rd, load, tv, em;
    int l, n;
    complete = len_low >= 10;
    rd = complete && f[9] && addr;
    l = 11 + d;
    load = rd && d > 0 && l < len_low;
    n = (len_low + 1 > 12) ? len_low + 1 : 12;
    if (complete && f[9]) addr = !addr;
    for (int e = 0; e < n; e++) begin
      if (rd && e >= 11 && (d == 0 || e <= l)) tv = load && e == l;
      else tv = ($urandom % 4) == 0;
      step(e >= len_low, (e >= 1 && e <= 10) ? f[10-e] : 1'($urandom), tv,
           (load && e == l) ? td : 8'($urandom));
      em = (load && e >= l + 1 && e <= l + 8 && e < len_low) ? td[l+8-e] : 1'b0;
      chk("rx_valid", 32'(rx_valid), 32'(complete && e == 11));
      chk("miso", 32'(MISO), 32'(em));
      if (complete && e == 11) chk("rx_data", 32'(rx_data), 32'(f));
      if (e == rst_at) begin
        rst_n = 1'b0;
        SS_n = 1'b1;
        tx_valid = 1'b0;
        #1;
        chk("rst_miso", 32'(MISO), 32'd0);
        chk("rst_rx_valid", 32'(rx_valid), 32'd0);
        chk("rst_rx_data", 32'(rx_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        addr = 1'b0;
        return;
      end
    end
  endtask
  initial begin
    int len;
    #2 rst_n = 1'b0;
    #1;
    chk("reset_miso", 32'(MISO), 32'd0);
    chk("reset_rx_valid", 32'(rx_valid), 32'd0);
    chk("reset_rx_data", 32'(rx_data), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    frame({CMD_WR_ADDR, 8'h05}, 11, 0, 8'h00, -1);
    frame({CMD_WR_DATA, 8'hAA}, 12, 0, 8'h00, -1);
    frame({CMD_RD_ADDR, 8'h05}, 11, 3, 8'h55, -1);
    frame({CMD_RD_DATA, 8'hC3}, 25, 1, 8'hAA, -1);
    frame({CMD_RD_DATA, 8'h00}, 25, 1, 8'hFF, -1);
    frame({CMD_RD_ADDR, 8'hAB}, 6, 0, 8'h00, -1);
    frame({CMD_WR_ADDR, 8'hF0}, 10, 0, 8'h00, -1);
    frame({CMD_WR_DATA, 8'h3C}, 9, 0, 8'h00, -1);
    frame({CMD_RD_DATA, 8'h12}, 30, 2, 8'hC9, 16);
    frame({CMD_RD_DATA, 8'hFF}, 25, 1, 8'h81, -1);
    frame({CMD_RD_DATA, 8'h5A}, 24, 2, 8'h96, -1);
    for (int i = 0; i < 300; i++) begin
      case ($urandom % 4)
        0: len = $urandom_range(0, 9);
        1: len = 10;
        2: len = 11;
        default: len = $urandom_range(12, 34);
      endcase
      frame(10'($urandom), len, $urandom_range(0, 4), 8'($urandom),
            ($urandom % 25 == 0) ? int'($urandom_range(0, 11)) : -1);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
